ws2812_frame_sequencer: RTL and testbench

WS2812_FRAME_SEQUENCER -- requirements
Module: ws2812_frame_sequencer

---
 rtl/ws2812_frame_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_ws2812_frame_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_sequencer.sv
// Frame sequencer for a WS2812 bit driver: walks a small pixel store, applies a
// global brightness scale and paces one driver load every PIXEL_TICKS clocks.
module ws2812_frame_sequencer #(
    parameter int NUM_LEDS    = 8,
    parameter int ADDR_W      = 3,
    parameter int PIXEL_TICKS = 73
) (
    input  logic              clk_400k,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic [7:0]        brightness,
    input  logic              frame_go,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              drv_start,
    output logic              drv_has_next,
    output logic [7:0]        drv_r,
    output logic [7:0]        drv_g,
    output logic [7:0]        drv_b,
    input  logic              drv_busy
);

    localparam int IDX_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(PIXEL_TICKS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIXEL_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [IDX_W-1:0]  idx_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [7:0]        bright_q;
    logic [IDX_W-1:0]  rd_idx;
    logic [23:0]       rd_pixel;
    logic [23:0]       rd_terms [NUM_LEDS];
    logic [7:0]        scale_bright;
    logic [23:0]       scaled_pixel;
    logic              last_tick;
    logic              reload;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    // Pixel store: one register per LED; reads are combinational so a same-edge
    // write is seen only from the following cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_pix
            logic [23:0] pix_reg;

            always_ff @(posedge clk_400k or negedge rst_n) begin
                if (!rst_n) begin
                    pix_reg <= '0;
                end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    pix_reg <= wr_data;
                end
            end

            assign rd_terms[gi] = (rd_idx == IDX_W'(gi)) ? pix_reg : 24'd0;
        end
    endgenerate

    always_comb begin
        rd_pixel = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            rd_pixel = rd_pixel | rd_terms[i];
        end
    end

    // Index of the pixel the driver will take next; past the end reads as black.
    always_comb begin
        case (state_reg)
            S_IDLE:  rd_idx = '0;
            S_LOAD:  rd_idx = IDX_W'(1);
            default: rd_idx = idx_reg + IDX_W'(2);
        endcase
    end

    assign scale_bright = (state_reg == S_IDLE) ? brightness : bright_q;
    assign scaled_pixel = {scale(rd_pixel[23:16], scale_bright),
                           scale(rd_pixel[15:8],  scale_bright),
                           scale(rd_pixel[7:0],   scale_bright)};

    assign last_tick = (state_reg == S_STREAM) && (cnt_reg == LAST_CNT);
    assign reload    = last_tick && (idx_reg < LAST_IDX);

    always_ff @(posedge clk_400k or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (frame_go)   state_next = S_LOAD;
            S_LOAD:   if (!drv_busy)  state_next = S_STREAM;
            S_STREAM: if (last_tick && (idx_reg == LAST_IDX)) state_next = S_DRAIN;
            S_DRAIN:  if (!drv_busy)  state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        frame_busy   = (state_reg != S_IDLE);
        frame_done   = (state_reg == S_DONE);
        drv_start    = 1'b0;
        drv_has_next = 1'b0;
        case (state_reg)
            S_LOAD: begin
                drv_start    = 1'b1;
                drv_has_next = (NUM_LEDS > 1);
            end
            S_STREAM: begin
                drv_start    = reload;
                drv_has_next = reload;
            end
            default: begin
            end
        endcase
    end

    // Datapath: pixel pacing counters, latched brightness and the colour
    // presented to the driver ahead of each load.
    always_ff @(posedge clk_400k or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg  <= '0;
            cnt_reg  <= '0;
            bright_q <= '0;
            drv_r    <= '0;
            drv_g    <= '0;
            drv_b    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (frame_go) begin
                        bright_q              <= brightness;
                        idx_reg               <= '0;
                        cnt_reg               <= '0;
                        {drv_r, drv_g, drv_b} <= scaled_pixel;
                    end
                end
                S_LOAD: begin
                    if (!drv_busy) begin
                        idx_reg               <= '0;
                        cnt_reg               <= '0;
                        {drv_r, drv_g, drv_b} <= scaled_pixel;
                    end
                end
                S_STREAM: begin
                    if (cnt_reg == LAST_CNT) begin
                        cnt_reg <= '0;
                        if (idx_reg < LAST_IDX) begin
                            idx_reg               <= idx_reg + IDX_W'(1);
                            {drv_r, drv_g, drv_b} <= scaled_pixel;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Bench for ws2812_frame_sequencer: a 3-LED and a 1-LED instance driven with
// random frames, writes, brightness changes and driver-busy timing.
module tb_ws2812_frame_sequencer;

    localparam int PT = 73;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [23:0] wr_data;
    logic [7:0]  brightness;
    logic        frame_go;
    logic        drv_busy;
    logic        sel;

    logic        go3, go1, wr_addr1;
    logic        fb3, fd3, st3, hn3;
    logic        fb1, fd1, st1, hn1;
    logic [7:0]  r3, g3, b3, r1, g1, b1;
    logic        m_busy, m_done, m_start, m_hn;
    logic [23:0] m_rgb;

    int          total = 0;
    int          bad   = 0;
    logic [23:0] mem3 [3];
    logic [23:0] mem1;

    always #5 clk = ~clk;

    assign go3      = frame_go & ~sel;
    assign go1      = frame_go & sel;
    assign wr_addr1 = (wr_addr != 3'd0);

    assign m_busy  = sel ? fb1 : fb3;
    assign m_done  = sel ? fd1 : fd3;
    assign m_start = sel ? st1 : st3;
    assign m_hn    = sel ? hn1 : hn3;
    assign m_rgb   = sel ? {r1, g1, b1} : {r3, g3, b3};

    ws2812_frame_sequencer #(.NUM_LEDS(3), .ADDR_W(3), .PIXEL_TICKS(PT)) dut3 (
        .clk_400k(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .brightness(brightness), .frame_go(go3),
        .frame_busy(fb3), .frame_done(fd3), .drv_start(st3), .drv_has_next(hn3),
        .drv_r(r3), .drv_g(g3), .drv_b(b3), .drv_busy(drv_busy)
    );

    ws2812_frame_sequencer #(.NUM_LEDS(1), .ADDR_W(1), .PIXEL_TICKS(PT)) dut1 (
        .clk_400k(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr1),
        .wr_data(wr_data), .brightness(brightness), .frame_go(go1),
        .frame_busy(fb1), .frame_done(fd1), .drv_start(st1), .drv_has_next(hn1),
        .drv_r(r1), .drv_g(g1), .drv_b(b1), .drv_busy(drv_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sc(input logic [7:0] c, input int b);
        return 8'((int'(c) * (b + 1)) / 256);
    endfunction

    function automatic logic [23:0] sc_px(input logic [23:0] p, input int b);
        return {sc(p[23:16], b), sc(p[15:8], b), sc(p[7:0], b)};
    endfunction

    task automatic model_write(input logic [2:0] a, input logic [23:0] d);
        if (a < 3'd3) mem3[a] = d;
        if (a == 3'd0) mem1 = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) mem3[i] = '0;
        mem1 = '0;
    endtask

    task automatic host_write(input logic [2:0] a, input logic [23:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        model_write(a, d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // One frame: s selects the 1-LED instance, p/g are driver-busy cycles
    // before the first load and after draining begins.
    task automatic run_frame(input bit s, input int b, input int p, input int g,
                             input bit spam, input bit rnd_wr, input int abort_t);
        int          n, last_c, done_c, exp_loads, stray, hn_only;
        bit          aborted;
        logic [23:0] exp_pix [3];
        int          obs_t [$];
        logic [23:0] obs_rgb [$];
        logic        obs_hn [$];
        int          done_t [$];
        logic [23:0] wd;
        logic [2:0]  wa;

        n       = s ? 1 : 3;
        last_c  = p + (n - 1) * PT;
        done_c  = p + n * PT + g + 2;
        aborted = 1'b0;
        stray   = 0;
        hn_only = 0;
        for (int i = 0; i < 3; i++) exp_pix[i] = '0;

        @(negedge clk);
        sel        = s;
        brightness = 8'(b);
        frame_go   = 1'b1;
        wr_en      = 1'b0;
        drv_busy   = 1'b0;
        exp_pix[0] = s ? mem1 : mem3[0];

        for (int t = 0; t <= done_c + 3; t++) begin
            @(negedge clk);
            frame_go   = spam && (t < done_c - 1) && ($urandom_range(0, 3) == 0);
            brightness = 8'($urandom_range(0, 255));
            drv_busy   = (t < p) || (t > last_c && t < p + n * PT + 1 + g);
            for (int k = 1; k < n; k++) begin
                if (t == p + (k - 1) * PT) exp_pix[k] = mem3[k];
            end
            wr_en = 1'b0;
            if (rnd_wr && t < done_c) begin
                if (n == 3 && t == p + PT) begin
                    wa = 3'd2; wd = 24'($urandom); wr_en = 1'b1;
                end else if ($urandom_range(0, 7) == 0) begin
                    wa = 3'($urandom_range(0, 7)); wd = 24'($urandom); wr_en = 1'b1;
                end
                if (wr_en) begin
                    wr_addr = wa;
                    wr_data = wd;
                    model_write(wa, wd);
                end
            end

            if (t == 0) begin
                check_eq("start_latency", 32'(m_start), 32'd1);
                check_eq("busy_in_frame", 32'(m_busy), 32'd1);
            end
            if (m_start && !drv_busy) begin
                obs_t.push_back(t);
                obs_rgb.push_back(m_rgb);
                obs_hn.push_back(m_hn);
            end
            if (m_start && drv_busy && t >= p) stray++;
            if (m_hn && !m_start) hn_only++;
            if (m_done) done_t.push_back(t);

            if (t == abort_t) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("abort_busy",  32'(m_busy),  32'd0);
                check_eq("abort_done",  32'(m_done),  32'd0);
                check_eq("abort_start", 32'(m_start), 32'd0);
                check_eq("abort_hn",    32'(m_hn),    32'd0);
                check_eq("abort_rgb",   32'(m_rgb),   32'd0);
                model_clear();
                wr_en    = 1'b0;
                frame_go = 1'b0;
                drv_busy = 1'b0;
                repeat (2) @(negedge clk);
                rst_n   = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        frame_go = 1'b0;
        wr_en    = 1'b0;
        drv_busy = 1'b0;

        exp_loads = aborted ? 2 : n;
        check_eq("num_loads", 32'(obs_t.size()), 32'(exp_loads));
        for (int k = 0; k < obs_t.size() && k < exp_loads; k++) begin
            check_eq($sformatf("load%0d_time", k), 32'(obs_t[k]), 32'(p + k * PT));
            check_eq($sformatf("load%0d_rgb", k), 32'(obs_rgb[k]), 32'(sc_px(exp_pix[k], b)));
            check_eq($sformatf("load%0d_has_next", k), 32'(obs_hn[k]),
                     (k == 0 && n == 1) ? 32'd0 : 32'd1);
        end
        check_eq("stray_start", 32'(stray), 32'd0);
        check_eq("has_next_alone", 32'(hn_only), 32'd0);
        check_eq("num_done", 32'(done_t.size()), aborted ? 32'd0 : 32'd1);
        if (!aborted && done_t.size() > 0) check_eq("done_time", 32'(done_t[0]), 32'(done_c));
        check_eq("idle_after", 32'(m_busy), 32'd0);
        $display("frame leds=%0d bright=%0d pre=%0d gap=%0d loads=%0d dones=%0d aborted=%0d",
                 n, b, p, g, obs_t.size(), done_t.size(), aborted);
    endtask

    initial begin
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        brightness = '0;
        frame_go   = 1'b0;
        drv_busy   = 1'b0;
        sel        = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_eq("rst_busy3",  32'(fb3), 32'd0);
        check_eq("rst_done3",  32'(fd3), 32'd0);
        check_eq("rst_start3", 32'(st3), 32'd0);
        check_eq("rst_hn3",    32'(hn3), 32'd0);
        check_eq("rst_rgb3",   32'({r3, g3, b3}), 32'd0);
        check_eq("rst_busy1",  32'(fb1), 32'd0);
        check_eq("rst_rgb1",   32'({r1, g1, b1}), 32'd0);
        rst_n = 1'b1;

        run_frame(1'b0, 255, 1, 2, 1'b0, 1'b0, -1);

        host_write(3'd0, 24'hFF0000);
        host_write(3'd1, 24'h00FF00);
        host_write(3'd2, 24'h0000FF);
        host_write(3'd7, 24'h123456);
        run_frame(1'b0, 255, 2, 3, 1'b0, 1'b0, -1);

        host_write(3'd0, 24'h804020);
        run_frame(1'b0, 127, 0, 1, 1'b0, 1'b1, -1);
        run_frame(1'b0, 127, 1, 0, 1'b0, 1'b0, -1);

        host_write(3'd0, 24'hA5C3E7);
        run_frame(1'b1, 200, 3, 2, 1'b1, 1'b0, -1);
        run_frame(1'b1, 0, 0, 0, 1'b0, 1'b0, -1);
        run_frame(1'b0, 90, 1, 4, 1'b1, 1'b1, -1);

        run_frame(1'b0, 255, 1, 2, 1'b0, 1'b1, 1 + PT + 10);
        host_write(3'd0, 24'($urandom));
        host_write(3'd1, 24'($urandom));
        host_write(3'd2, 24'($urandom));
        run_frame(1'b0, 255, 0, 1, 1'b0, 1'b0, -1);

        for (int i = 0; i < 4; i++) begin
            run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 255),
                      $urandom_range(0, 4), $urandom_range(0, 4),
                      1'($urandom_range(0, 1)), 1'b1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
